// File: rtl/hamming_frame_acc_pkg.sv
// Shared constants and FSM state type for the hamming frame accumulator slice.
package hamming_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned POP_WIDTH  = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/hamming16.sv
// Population count of one 16-bit word (pure combinational).
module hamming16
  import hamming_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic [POP_WIDTH-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      count_o = count_o + POP_WIDTH'(data_i[i]);
    end
  end

endmodule

// File: rtl/hamming_frame_acc.sv
// Per-frame popcount/word-count accumulator on valid/ready streams.
// HAMMING_FRAME_ACC_SAT_EN: saturate accumulators and report clipping on out_ovf.
module hamming_frame_acc
  import hamming_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_total,
  output logic [ACC_WIDTH-1:0]  out_words,
  output logic                  out_ovf
);

  acc_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_total_q, acc_total_d;
  logic [ACC_WIDTH-1:0] acc_words_q, acc_words_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic [ACC_WIDTH-1:0] out_total_q, out_total_d;
  logic [ACC_WIDTH-1:0] out_words_q, out_words_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [POP_WIDTH-1:0] pop;
  logic [ACC_WIDTH-1:0] tot_next, words_next;
  logic                 ovf_beat;
  logic                 accept;

  hamming16 u_pop (
    .data_i  (in_data),
    .count_o (pop)
  );

`ifdef HAMMING_FRAME_ACC_SAT_EN
  logic [ACC_WIDTH:0] tot_sum, words_sum;

  always_comb begin
    tot_sum    = {1'b0, acc_total_q} + (ACC_WIDTH+1)'(pop);
    words_sum  = {1'b0, acc_words_q} + (ACC_WIDTH+1)'(1);
    tot_next   = tot_sum[ACC_WIDTH]   ? '1 : tot_sum[ACC_WIDTH-1:0];
    words_next = words_sum[ACC_WIDTH] ? '1 : words_sum[ACC_WIDTH-1:0];
    ovf_beat   = tot_sum[ACC_WIDTH] | words_sum[ACC_WIDTH];
  end
`else
  always_comb begin
    tot_next   = acc_total_q + ACC_WIDTH'(pop);
    words_next = acc_words_q + ACC_WIDTH'(1);
    ovf_beat   = 1'b0;
  end
`endif

  // HOLD passes out_ready straight through so a retiring result never costs a bubble.
  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == ACCUM) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_total = out_total_q;
  assign out_words = out_words_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_total_d = acc_total_q;
    acc_words_d = acc_words_q;
    acc_ovf_d   = acc_ovf_q;
    out_total_d = out_total_q;
    out_words_d = out_words_q;
    out_ovf_d   = out_ovf_q;

    if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
    end

    // Accumulators are already clear in HOLD, so the same adder serves both states.
    if (accept) begin
      if (in_last) begin
        out_total_d = tot_next;
        out_words_d = words_next;
        out_ovf_d   = acc_ovf_q | ovf_beat;
        acc_total_d = '0;
        acc_words_d = '0;
        acc_ovf_d   = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_total_d = tot_next;
        acc_words_d = words_next;
        acc_ovf_d   = acc_ovf_q | ovf_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_total_q <= '0;
      acc_words_q <= '0;
      acc_ovf_q   <= 1'b0;
      out_total_q <= '0;
      out_words_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_total_q <= acc_total_d;
      acc_words_q <= acc_words_d;
      acc_ovf_q   <= acc_ovf_d;
      out_total_q <= out_total_d;
      out_words_q <= out_words_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: doc/hamming_frame_acc.md
Name: hamming_frame_acc

Overview:
- Streaming stage directly downstream of hamming16: consumes a valid/ready stream of 16-bit words grouped into frames by a last flag.
- Instantiates hamming16 on the accepted input word and accumulates the per-word popcounts.
- Emits one result per frame (total set bits, word count) on a valid/ready output.
- Sits between a word source (e.g. FIFO or bus slave) and a result consumer.

Parameters:
- ACC_WIDTH, 12, width of the total and word-count accumulators; legal range 5..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  16  word to count.
- in_last  input  1  word is the final word of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_total  output  ACC_WIDTH  sum of popcounts over the frame.
- out_words  output  ACC_WIDTH  number of words in the frame.
- out_ovf  output  1  an accumulator exceeded its range during the frame.

Behaviour:
- One clock, clk; reset is synchronous and active-high. Reset has priority over every other event in the same cycle.
- Reset values:
  - state=ACCUM; out_valid=0; out_total=0; out_words=0; out_ovf=0.
  - Internal acc_total=0, acc_words=0, acc_ovf=0.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output beat completes when out_valid && out_ready.
  - out_* hold stable while out_valid=1 and out_ready=0.
- States:
  - ACCUM: out_valid=0; in_ready=1.
  - HOLD: out_valid=1; in_ready=out_ready (bypass, no bubble).
- Accepted beat with in_last=0:
  - acc_total += popcount(in_data), zero-extended 5->ACC_WIDTH.
  - acc_words += 1.
- Accepted beat with in_last=1:
  - out_total <= acc_total + popcount; out_words <= acc_words + 1; out_ovf <= acc_ovf | this beat's overflow.
  - Internal accumulators cleared to 0; next state HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- HOLD with out_ready=1: result retires. The same cycle may accept a new beat.
  - Non-last beat: accumulates into the cleared accumulators; next state ACCUM.
  - Last beat (1-word frame): loads new out_* directly; stays in HOLD.
- HOLD with out_ready=0: in_ready=0; nothing accepted; accumulators frozen.
- Single-word frame (in_last on first beat): out_words=1, out_total=popcount.
- in_data=0 contributes 0 but still increments out_words.
- Overflow (total or word count exceeding 2^ACC_WIDTH-1): behaviour per the optional feature.
- Reset mid-frame or mid-HOLD: partial frame and pending result are discarded; no output beat.

Optional Feature:
- Macro: HAMMING_FRAME_ACC_SAT_EN.
- Defined:
  - Both accumulators saturate at 2^ACC_WIDTH-1.
  - Any clipped addition sets acc_ovf (sticky per frame), reported on out_ovf.
- Undefined:
  - Accumulators wrap modulo 2^ACC_WIDTH.
  - out_ovf tied to 0.

Decomposition:
- Package hamming_pkg:
  - WORD_WIDTH=16; POP_WIDTH=5.
  - Enum typedef acc_state_t {ACCUM, HOLD}.
- Sub-module: existing hamming16 instantiated unchanged on in_data. No other sub-module.

Test Plan:
- Frame of 3 words 16'hFFFF, 16'h0001, 16'h00F0 (last on 3rd), out_ready=1 -> one result: out_total=21, out_words=3, out_ovf=0; out_valid high exactly 1 cycle after the 3rd accept.
- Back-to-back single-word frames 16'hAAAA then 16'h0000, out_ready held 1, in_valid held 1 -> in_ready never drops; results (8,1) then (0,1) on consecutive cycles.
- Result pending with out_ready=0 for 5 cycles -> in_ready=0 and out_* stable throughout; out_ready=1 with new non-last beat 16'h000F -> result retires and next frame starts with acc_total=4.
- ACC_WIDTH=5, frame of 3 x 16'hFFFF -> SAT_EN defined: out_total=31, out_ovf=1. Undefined: out_total=48 mod 32=16, out_ovf=0.
- Reset asserted after 2 non-last beats -> all outputs 0; next 1-word frame 16'h0003 yields (2,1), with no residue from the aborted frame.
- Randomised frames (lengths 1..8, random data and out_ready) vs reference model summing popcounts -> every result matches, no dropped or duplicated frames.
